// File: rtl/mem_pkg.sv
// Shared encodings for data-memory access sizes and the alignment rule.
// Pure declarations; no timing.
// No flow control.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a memory word and extends it.
// Purely combinational, zero latency.
// No flow control.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: result = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory with sized, extended loads.
// Latency 1: valid/err/rdata register on the edge after the sampled request.
// Never stalls; one request accepted every cycle.
module data_mem
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        err
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  size_e             sz;
  logic              mis;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       rd_word;
  logic [31:0]       ld_res;
  logic              unused_addr_hi;

  assign idx     = addr[ADDR_W+1:2];
  assign off     = addr[1:0];
  assign sz      = size_e'(size);
  assign mis     = misaligned(sz, off);
  assign rd_word = mem[idx];
  // Upper address bits alias onto the same words by design.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    case (sz)
      SZ_BYTE: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata;
      end
    endcase
  end

  load_align u_load_align (
    .word   (rd_word),
    .offset (off),
    .size   (sz),
    .uns    (uns),
    .result (ld_res)
  );

  // Memory contents survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && req && we && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= req;
      err   <= req && mis;
      if (req) rdata <= (we || mis) ? 32'b0 : ld_res;
    end
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL provide parameter: ADDR_W, 8, log2 of word depth (256 words = 1 KiB).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port: req  input  1  access request, sampled on clk rise.
REQ-005 SHALL provide port: we  input  1  1 = store, 0 = load; meaningful only when req=1.
REQ-006 SHALL provide port: size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL provide port: uns  input  1  1 = zero-extend load, 0 = sign-extend; ignored for word and stores.
REQ-008 SHALL provide port: addr  input  32  byte address, driven by the ALU result.
REQ-009 SHALL provide port: wdata  input  32  store data; the low byte/half/word is used according to size.
REQ-010 SHALL provide port: rdata  output  32  extended load result.
REQ-011 SHALL provide port: valid  output  1  one-cycle pulse when an access completes.
REQ-012 SHALL provide port: err  output  1  one-cycle pulse, coincident with valid, for a misaligned or reserved-size access.

Function
REQ-013 SHALL store ADDR_W-indexed 32-bit words, word index = addr[ADDR_W+1:2], upper address bits ignored (aliasing wrap).
REQ-014 SHALL be little-endian: byte offset addr[1:0]=k maps to word bits [8k+7:8k].
REQ-015 SHALL complete every request with latency 1: valid=1 in the cycle after the request's sampling edge, with rdata/err valid in that same cycle.
REQ-016 SHALL accept a new request every cycle (no stall); back-to-back requests each yield one valid pulse.
REQ-017 SHALL flag misalignment when size=01 and addr[0]=1, when size=10 and addr[1:0]!=0, or when size=11.
REQ-018 SHALL, on a misaligned store, leave memory unchanged, assert err with valid, and drive rdata=0.
REQ-019 SHALL, on a misaligned load, assert err with valid and drive rdata=0.
REQ-020 SHALL, on an aligned store, update only the addressed byte lanes at the sampling edge; rdata=0 and err=0 in the completion cycle.
REQ-021 SHALL, on an aligned load, return the selected byte/half, sign- or zero-extended per uns, or the full word.
REQ-022 SHALL return, for a load in the cycle immediately following a store to the same word, the post-store data (read-after-write ordering).
REQ-023 SHALL hold rdata at its last value and keep valid=0 and err=0 while no request completes.
REQ-024 SHALL treat we, size, uns, addr and wdata as don't-care when req=0; no memory write occurs.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, set valid=0, err=0 and rdata=0, and discard any request sampled at that edge (no write, no completion).
REQ-026 SHALL NOT clear memory contents on reset; contents are undefined until written.
REQ-027 SHALL, when reset asserts in a completion cycle, suppress the next-cycle pulse; the first valid after reset follows the first req sampled with rst_n=1.

Structure
REQ-028 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) in shared package mem_pkg, which the controller also uses.
REQ-029 SHALL implement load extraction and extension in one sub-module, load_align (inputs: word, offset, size, uns; output: 32-bit result), which is purely combinational.
REQ-030 SHALL produce the store byte-enable and lane-replicated write data locally in data_mem.

Verification
REQ-031 SHALL verify word round-trip: sw 0xDEADBEEF @0x10, then lw @0x10 -> valid next cycle, rdata=0xDEADBEEF, err=0.
REQ-032 SHALL verify byte lanes: sw 0x11223344 @0x20, then sb 0xAA @0x22, then lw @0x20 -> 0x11AA3344; lb @0x22 -> 0xFFFFFFAA; lbu -> 0x000000AA.
REQ-033 SHALL verify halfword: sh 0x8001 @0x32, then lh @0x32 -> 0xFFFF8001 and lhu -> 0x00008001.
REQ-034 SHALL verify misalignment: sw 0x12345678 @0x41 -> err=1, rdata=0, and a later lw @0x40 returns its prior value; lh @0x43 -> err=1.
REQ-035 SHALL verify reset and aliasing: pulse rst_n=0 in the cycle after req -> no valid; sw 0xCAFEF00D @0x400 then lw @0x000 (ADDR_W=8) -> 0xCAFEF00D.
REQ-036 SHALL verify back-to-back requests: sw @0x8 then lw @0x8 on consecutive cycles -> two valid pulses, and the load returns the stored data.
